// File: rtl/pedestal_selftrigger_bank.sv
// rtl/pedestal_selftrigger_bank.sv - multi-channel EMA pedestal tracker with per-channel self-trigger
module pedestal_selftrigger_bank #(
  parameter int N_CH       = 40,
  parameter int DW         = 16,
  parameter int TH_W       = 32,
  parameter int BASE_SHIFT = 6,
  parameter int HO_W       = 8,
  parameter int CNT_W      = 16,
  parameter int AW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_CH*DW-1:0]   x,
  input  logic                 x_valid,
  output logic [N_CH*DW-1:0]   y,
  output logic                 y_valid,
  output logic [N_CH-1:0]      trigger,
  input  logic                 cfg_we,
  input  logic                 cfg_re,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [1:0]           cfg_sel,
  input  logic [TH_W-1:0]      cfg_wdata,
  output logic [TH_W-1:0]      cfg_rdata,
  output logic                 cfg_rvalid
);

  localparam int ACC_W = DW + BASE_SHIFT + 1;
  localparam logic signed [DW:0]     Y_MAX   = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [DW:0]     Y_MIN   = {2'b11, {(DW-1){1'b0}}};
  localparam logic signed [TH_W-1:0] THR_RST = {1'b0, {(TH_W-1){1'b1}}};

  typedef enum logic [1:0] {S_INIT, S_ARMED, S_HOLD} state_t;

  state_t                  state_q [N_CH];
  state_t                  state_d [N_CH];
  logic signed [ACC_W-1:0] acc_q   [N_CH];
  logic signed [ACC_W-1:0] acc_d   [N_CH];
  logic [HO_W-1:0]         ho_q    [N_CH];
  logic [HO_W-1:0]         ho_d    [N_CH];
  logic signed [TH_W-1:0]  thr_q   [N_CH];
  logic signed [TH_W-1:0]  hyst_q  [N_CH];
  logic [HO_W-1:0]         hold_q  [N_CH];
  logic [CNT_W-1:0]        cnt_q   [N_CH];

  logic [N_CH*DW-1:0]      y_q, y_d;
  logic                    y_valid_q;
  logic [N_CH-1:0]         trig_q, fire_d;
  logic [TH_W-1:0]         rdata_q, rdata_d;
  logic                    rvalid_q;

  logic signed [DW-1:0]    xs_a      [N_CH];
  logic signed [DW-1:0]    ysat_a    [N_CH];
  logic signed [ACC_W-1:0] acc_upd_a [N_CH];
  logic [N_CH-1:0]         above_a, rearm_a;

  // Baseline is acc>>>BASE_SHIFT; the top DW+1 bits of acc are exactly that value.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic signed [DW:0]     base;
    logic signed [DW:0]     diff;
    logic signed [TH_W-1:0] diff_ext;
    logic signed [TH_W:0]   rearm_lvl;

    assign xs_a[c]      = x[c*DW +: DW];
    assign base         = acc_q[c][ACC_W-1:BASE_SHIFT];
    assign diff         = {xs_a[c][DW-1], xs_a[c]} - base;
    assign diff_ext     = TH_W'(diff);
    assign rearm_lvl    = (TH_W+1)'(thr_q[c]) - (TH_W+1)'(hyst_q[c]);
    assign above_a[c]   = diff_ext > thr_q[c];
    assign rearm_a[c]   = (TH_W+1)'(diff) <= rearm_lvl;
    assign ysat_a[c]    = (diff > Y_MAX) ? Y_MAX[DW-1:0] :
                          (diff < Y_MIN) ? Y_MIN[DW-1:0] : diff[DW-1:0];
    assign acc_upd_a[c] = acc_q[c] + ACC_W'(xs_a[c]) - ACC_W'(base);
  end

  always_comb begin
    y_d    = y_q;
    fire_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      state_d[c] = state_q[c];
      acc_d[c]   = acc_q[c];
      ho_d[c]    = ho_q[c];
      if (!enable) begin
        state_d[c] = S_INIT;
        if (x_valid) y_d[c*DW +: DW] = xs_a[c];
      end else if (x_valid) begin
        case (state_q[c])
          S_INIT: begin
            acc_d[c]         = ACC_W'(xs_a[c]) <<< BASE_SHIFT;
            y_d[c*DW +: DW]  = '0;
            state_d[c]       = S_ARMED;
          end
          S_ARMED: begin
            y_d[c*DW +: DW] = ysat_a[c];
            if (above_a[c]) begin
              fire_d[c]  = 1'b1;
              ho_d[c]    = hold_q[c];
              state_d[c] = S_HOLD;
            end else begin
              acc_d[c] = acc_upd_a[c];
            end
          end
          S_HOLD: begin
            y_d[c*DW +: DW] = ysat_a[c];
            if (ho_q[c] != '0)  ho_d[c]    = ho_q[c] - 1'b1;
            else if (rearm_a[c]) state_d[c] = S_ARMED;
          end
          default: state_d[c] = S_INIT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= S_INIT;
        acc_q[c]   <= '0;
        ho_q[c]    <= '0;
      end
      y_q       <= '0;
      y_valid_q <= 1'b0;
      trig_q    <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= state_d[c];
        acc_q[c]   <= acc_d[c];
        ho_q[c]    <= ho_d[c];
      end
      y_q       <= y_d;
      y_valid_q <= x_valid;
      trig_q    <= fire_d;
    end
  end

  logic addr_ok;
  assign addr_ok = (32'(cfg_addr) < 32'(N_CH));

  always_comb begin
    rdata_d = '0;
    if (addr_ok) begin
      case (cfg_sel)
        2'b00:   rdata_d = thr_q[cfg_addr];
        2'b01:   rdata_d = TH_W'(hold_q[cfg_addr]);
        2'b10:   rdata_d = hyst_q[cfg_addr];
        default: rdata_d = TH_W'(cnt_q[cfg_addr]);
      endcase
    end
  end

  // A count clear coinciding with a trigger leaves that trigger counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        thr_q[c]  <= THR_RST;
        hold_q[c] <= HO_W'(16);
        hyst_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (cfg_we && cfg_addr == AW'(c)) begin
          case (cfg_sel)
            2'b00:   thr_q[c]  <= cfg_wdata;
            2'b01:   hold_q[c] <= cfg_wdata[HO_W-1:0];
            2'b10:   hyst_q[c] <= cfg_wdata;
            default: ;
          endcase
        end
        if (cfg_we && cfg_sel == 2'b11 && cfg_addr == AW'(c))
          cnt_q[c] <= fire_d[c] ? CNT_W'(1) : '0;
        else if (fire_d[c] && cnt_q[c] != '1)
          cnt_q[c] <= cnt_q[c] + 1'b1;
      end
      if (cfg_re) rdata_q <= rdata_d;
      rvalid_q <= cfg_re;
    end
  end

  assign y          = y_q;
  assign y_valid    = y_valid_q;
  assign trigger    = trig_q;
  assign cfg_rdata  = rdata_q;
  assign cfg_rvalid = rvalid_q;

endmodule

// File: tb/tb_pedestal_selftrigger_bank.sv
// tb/tb_pedestal_selftrigger_bank.sv - directed self-checking bench for pedestal_selftrigger_bank
module tb_pedestal_selftrigger_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [63:0] x;
  logic        x_valid;
  logic [63:0] y;
  logic        y_valid;
  logic [3:0]  trigger;
  logic        cfg_we, cfg_re;
  logic [1:0]  cfg_addr, cfg_sel;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic        cfg_rvalid;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd;

  localparam logic [63:0] THR_MAX = 64'h7FFF_FFFF;

  pedestal_selftrigger_bank #(
    .N_CH(4), .DW(16), .TH_W(32), .BASE_SHIFT(4), .HO_W(8), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .x(x), .x_valid(x_valid), .y(y), .y_valid(y_valid), .trigger(trigger),
    .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic drive(input logic [63:0] xv);
    @(negedge clk);
    x = xv;
    x_valid = 1'b1;
    @(posedge clk);
    #1;
    x_valid = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int sel, input int data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 2'(ch); cfg_sel = 2'(sel); cfg_wdata = 32'(data);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input int ch, input int sel, output logic [31:0] d);
    @(negedge clk);
    cfg_re = 1'b1; cfg_addr = 2'(ch); cfg_sel = 2'(sel);
    @(posedge clk);
    #1;
    cfg_re = 1'b0;
    d = cfg_rdata;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; x = '0; x_valid = 1'b0;
    cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = '0; cfg_sel = '0; cfg_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_y", y, 64'd0);
    check_eq("rst_yvalid", 64'(y_valid), 64'd0);
    check_eq("rst_trig", 64'(trigger), 64'd0);
    check_eq("rst_rvalid", 64'(cfg_rvalid), 64'd0);
    check_eq("rst_rdata", 64'(cfg_rdata), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    cfg_read(0, 0, rd);
    check_eq("rvalid_pulse", 64'(cfg_rvalid), 64'd1);
    check_eq("thr0_reset", 64'(rd), THR_MAX);
    idle_cycle();
    check_eq("rvalid_drop", 64'(cfg_rvalid), 64'd0);

    for (int i = 0; i < 100; i++) begin
      drive(pk(8000, 8000, 8000, 8000));
      check_eq("flat_y", y, 64'd0);
      check_eq("flat_trig", 64'(trigger), 64'd0);
    end
    for (int c = 0; c < 4; c++) begin
      cfg_read(c, 3, rd);
      check_eq("flat_cnt", 64'(rd), 64'd0);
    end

    cfg_write(2, 0, 100);
    cfg_write(2, 1, 5);
    cfg_write(2, 2, 20);
    drive(pk(8000, 8000, 8200, 8000));
    check_eq("trig1", 64'(trigger), 64'h4);
    check_eq("trig1_y", y, pk(0, 0, 200, 0));
    check_eq("trig1_yvalid", 64'(y_valid), 64'd1);
    idle_cycle();
    check_eq("trig1_pulse", 64'(trigger), 64'd0);
    check_eq("idle_yvalid", 64'(y_valid), 64'd0);
    check_eq("idle_yhold", y, pk(0, 0, 200, 0));
    cfg_read(2, 3, rd);
    check_eq("cnt2_a", 64'(rd), 64'd1);
    cfg_read(2, 1, rd);
    check_eq("ho2_read", 64'(rd), 64'd5);

    for (int i = 0; i < 10; i++) begin
      drive(pk(8000, 8000, 8200, 8000));
      check_eq("hold_trig", 64'(trigger), 64'd0);
      check_eq("hold_y", y, pk(0, 0, 200, 0));
    end
    drive(pk(8000, 8000, 8000, 8000));
    check_eq("rearm_trig", 64'(trigger), 64'd0);
    check_eq("rearm_y", y, 64'd0);
    drive(pk(8000, 8000, 8200, 8000));
    check_eq("trig2", 64'(trigger), 64'h4);
    check_eq("trig2_y", y, pk(0, 0, 200, 0));
    cfg_read(2, 3, rd);
    check_eq("cnt2_b", 64'(rd), 64'd2);

    for (int i = 0; i < 5; i++) begin
      drive(pk(8000, 8000, 8090, 8000));
      check_eq("hys_cd_trig", 64'(trigger), 64'd0);
      check_eq("hys_cd_y", y, pk(0, 0, 90, 0));
    end
    drive(pk(8000, 8000, 8090, 8000));
    check_eq("hys_stay", 64'(trigger), 64'd0);
    drive(pk(8000, 8000, 8200, 8000));
    check_eq("hys_still_hold", 64'(trigger), 64'd0);
    drive(pk(8000, 8000, 8070, 8000));
    check_eq("hys_rearm_trig", 64'(trigger), 64'd0);
    check_eq("hys_rearm_y", y, pk(0, 0, 70, 0));
    drive(pk(8000, 8000, 8200, 8000));
    check_eq("trig3", 64'(trigger), 64'h4);
    cfg_read(2, 3, rd);
    check_eq("cnt2_c", 64'(rd), 64'd3);

    cfg_write(1, 0, 100);
    cfg_write(1, 1, 0);
    drive(pk(8000, 8200, 8000, 8000));
    check_eq("ch1_trig", 64'(trigger), 64'h2);
    check_eq("ch1_y", y, pk(0, 200, 0, 0));
    cfg_read(1, 3, rd);
    check_eq("cnt1_a", 64'(rd), 64'd1);
    drive(pk(8000, 8000, 8000, 8000));
    check_eq("ch1_ho0_rearm", 64'(trigger), 64'd0);
    @(negedge clk);
    x = pk(8000, 8200, 8000, 8000); x_valid = 1'b1;
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_sel = 2'd3; cfg_wdata = '0;
    @(posedge clk);
    #1;
    x_valid = 1'b0; cfg_we = 1'b0;
    check_eq("clr_trig", 64'(trigger), 64'h2);
    cfg_read(1, 3, rd);
    check_eq("clr_inc_cnt", 64'(rd), 64'd1);

    enable = 1'b0;
    drive(pk(100, -5, 8200, 1234));
    check_eq("dis_y", y, pk(100, -5, 8200, 1234));
    check_eq("dis_trig", 64'(trigger), 64'd0);
    check_eq("dis_yvalid", 64'(y_valid), 64'd1);
    enable = 1'b1;
    drive(pk(8000, 8000, 8200, 8000));
    check_eq("reen_y", y, 64'd0);
    check_eq("reen_trig", 64'(trigger), 64'd0);

    enable = 1'b0;
    idle_cycle();
    enable = 1'b1;
    drive(pk(-30000, 8000, 8000, 8000));
    check_eq("satp_init", y, 64'd0);
    drive(pk(32767, 8000, 8000, 8000));
    check_eq("satp_y", y, pk(32767, 0, 0, 0));
    check_eq("satp_trig", 64'(trigger), 64'd0);
    enable = 1'b0;
    idle_cycle();
    enable = 1'b1;
    drive(pk(30000, 8000, 8000, 8000));
    check_eq("satn_init", y, 64'd0);
    drive(pk(-32768, 8000, 8000, 8000));
    check_eq("satn_y", y, pk(-32768, 0, 0, 0));

    @(negedge clk);
    cfg_we = 1'b1; cfg_re = 1'b1; cfg_addr = 2'd3; cfg_sel = 2'd0; cfg_wdata = 32'd55;
    @(posedge clk);
    #1;
    cfg_we = 1'b0; cfg_re = 1'b0;
    check_eq("rw_same_old", 64'(cfg_rdata), THR_MAX);
    cfg_read(3, 0, rd);
    check_eq("rw_new", 64'(rd), 64'd55);

    @(negedge clk);
    x = pk(8000, 8000, 8200, 8000); x_valid = 1'b1;
    cfg_re = 1'b1; cfg_addr = 2'd2; cfg_sel = 2'd0;
    @(posedge clk);
    #1;
    x_valid = 1'b0; cfg_re = 1'b0;
    check_eq("pre_rst_trig", 64'(trigger), 64'h4);
    check_eq("pre_rst_rdata", 64'(cfg_rdata), 64'd100);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_y", y, 64'd0);
    check_eq("mid_rst_trig", 64'(trigger), 64'd0);
    check_eq("mid_rst_yvalid", 64'(y_valid), 64'd0);
    check_eq("mid_rst_rvalid", 64'(cfg_rvalid), 64'd0);
    check_eq("mid_rst_rdata", 64'(cfg_rdata), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    cfg_read(2, 0, rd);
    check_eq("post_rst_thr", 64'(rd), THR_MAX);
    cfg_read(2, 3, rd);
    check_eq("post_rst_cnt", 64'(rd), 64'd0);
    cfg_read(2, 1, rd);
    check_eq("post_rst_ho", 64'(rd), 64'd16);
    drive(pk(8000, 8000, 8200, 8000));
    check_eq("post_rst_init_y", y, 64'd0);
    check_eq("post_rst_trig", 64'(trigger), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
